// File: rtl/horner_ctrl.sv
// Memory-mapped cubic polynomial evaluator: p(X) = C3*X^3 + C2*X^2 + C1*X + C0,
// computed by Horner's method with a 4-cycle shift-add multiply per step.
module horner_ctrl (
  input  logic        iClk,
  input  logic        iReset_n,
  input  logic        iChipSelect_n,
  input  logic        iWrite_n,
  input  logic        iRead_n,
  input  logic [2:0]  iAddress,
  input  logic [31:0] iData,
  output logic [31:0] oData,
  output logic        oIrq
);

  typedef enum logic [1:0] {IDLE, MUL, ADD} state_t;

  state_t           state;
  logic [3:0][3:0]  coef, scoef;
  logic [3:0]       x, sx;
  logic             irq_en, done, busy;
  logic [15:0]      result, acc, prod;
  logic [1:0]       k, i;

  logic        wr, rd, start;
  logic [31:0] rd_mux;
  logic [15:0] sum;

  assign wr    = ~iChipSelect_n & ~iWrite_n;
  assign rd    = ~iChipSelect_n & ~iRead_n;
  assign start = wr && (iAddress == 3'd5) && iData[0] && (state == IDLE);
  assign sum   = prod + {12'b0, scoef[k]};
  assign oIrq  = done & irq_en;

  always_comb begin
    rd_mux = 32'b0;
    case (iAddress)
      3'd0, 3'd1, 3'd2, 3'd3: rd_mux = {28'b0, coef[iAddress[1:0]]};
      3'd4:                   rd_mux = {28'b0, x};
      3'd5:                   rd_mux = {29'b0, irq_en, done, busy};
      3'd6:                   rd_mux = {16'b0, result};
      default:                rd_mux = 32'b0;
    endcase
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state  <= IDLE;
      oData  <= '0;
      coef   <= '0;
      scoef  <= '0;
      x      <= '0;
      sx     <= '0;
      irq_en <= 1'b0;
      done   <= 1'b0;
      busy   <= 1'b0;
      result <= '0;
      acc    <= '0;
      prod   <= '0;
      k      <= '0;
      i      <= '0;
    end else begin
      if (rd) oData <= rd_mux;

      if (wr) begin
        case (iAddress)
          3'd0, 3'd1, 3'd2, 3'd3: coef[iAddress[1:0]] <= iData[3:0];
          3'd4:                   x <= iData[3:0];
          3'd5: begin
            irq_en <= iData[1];
            if (iData[2]) done <= 1'b0;
          end
          default: ;
        endcase
      end

      // Completion is assigned after done_clear so it wins on a shared edge.
      case (state)
        IDLE: if (start) begin
          scoef <= coef;
          sx    <= x;
          acc   <= {12'b0, coef[3]};
          prod  <= '0;
          k     <= 2'd2;
          i     <= 2'd0;
          busy  <= 1'b1;
          done  <= 1'b0;
          state <= MUL;
        end
        MUL: begin
          if (sx[i]) prod <= prod + (acc << i);
          i <= i + 2'd1;
          if (i == 2'd3) state <= ADD;
        end
        ADD: begin
          acc  <= sum;
          prod <= '0;
          i    <= 2'd0;
          if (k != 2'd0) begin
            k     <= k - 2'd1;
            state <= MUL;
          end else begin
            result <= sum;
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_horner_ctrl.sv
// Randomized and directed bench for horner_ctrl against a plain-arithmetic polynomial model.
module tb_horner_ctrl;
  logic        iClk = 1'b0;
  logic        iReset_n = 1'b0;
  logic        cs_n = 1'b1, wr_n = 1'b1, rd_n = 1'b1;
  logic [2:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] oData;
  logic        oIrq;
  int          tests = 0, fails = 0;
  int          cyc = 0;

  horner_ctrl dut (
    .iClk(iClk), .iReset_n(iReset_n), .iChipSelect_n(cs_n), .iWrite_n(wr_n),
    .iRead_n(rd_n), .iAddress(addr), .iData(wdata), .oData(oData), .oIrq(oIrq)
  );

  always #5 iClk = ~iClk;
  always @(posedge iClk) cyc <= cyc + 1;

  function automatic int poly(int c0, int c1, int c2, int c3, int xv);
    return c3 * xv * xv * xv + c2 * xv * xv + c1 * xv + c0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Bus tasks are entered at a negedge; the access lands on the next posedge.
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    addr = a; wdata = d; cs_n = 1'b0; wr_n = 1'b0;
    @(negedge iClk);
    cs_n = 1'b1; wr_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    addr = a; cs_n = 1'b0; rd_n = 1'b0;
    @(negedge iClk);
    cs_n = 1'b1; rd_n = 1'b1;
    v = oData;
  endtask

  task automatic load(input int c0, input int c1, input int c2, input int c3, input int xv);
    wr(3'd0, 32'(c0)); wr(3'd1, 32'(c1)); wr(3'd2, 32'(c2));
    wr(3'd3, 32'(c3)); wr(3'd4, 32'(xv));
  endtask

  // Polls CTRL every cycle; done observed in a sample means it rose on the previous edge.
  task automatic wait_done(input string tag, input int t0);
    bit seen = 0, busy_ok = 1;
    addr = 3'd5; cs_n = 1'b0; rd_n = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge iClk);
      if (oData[1]) begin seen = 1; break; end
      if (oData[0] !== 1'b1) busy_ok = 0;
    end
    cs_n = 1'b1; rd_n = 1'b1;
    chk({tag, "_done"}, 32'(seen), 32'd1);
    chk({tag, "_busy_during"}, 32'(busy_ok), 32'd1);
    chk({tag, "_busy_after"}, 32'(oData[0]), 32'd0);
    chk({tag, "_latency"}, 32'(cyc - 1 - t0), 32'd15);
  endtask

  task automatic run_check(input string tag, input int c0, input int c1, input int c2,
                           input int c3, input int xv, input bit ien);
    logic [31:0] v;
    int t0;
    load(c0, c1, c2, c3, xv);
    wr(3'd5, {30'b0, ien, 1'b1});
    t0 = cyc;
    wait_done(tag, t0);
    rd(3'd6, v);
    chk({tag, "_result"}, v, 32'(poly(c0, c1, c2, c3, xv)));
    chk({tag, "_irq"}, 32'(oIrq), 32'(ien));
    rd(3'd5, v);
    chk({tag, "_status"}, v, ien ? 32'h6 : 32'h2);
  endtask

  initial begin
    logic [31:0] v;
    int t0, c[5];
    bit irq_seen;

    repeat (3) @(negedge iClk);
    chk("rst_odata", oData, 32'h0);
    chk("rst_irq", 32'(oIrq), 32'h0);
    iReset_n = 1'b1;
    @(negedge iClk);
    for (int a = 0; a < 8; a++) begin
      rd(3'(a), v);
      chk($sformatf("rst_reg%0d", a), v, 32'h0);
    end
    chk("rst_irq_after", 32'(oIrq), 32'h0);

    run_check("basic", 1, 2, 3, 4, 2, 1'b0);
    run_check("max", 15, 15, 15, 15, 15, 1'b1);
    wr(3'd5, 32'h6);
    chk("max_clear_irq", 32'(oIrq), 32'h0);
    run_check("x0", 9, 5, 6, 7, 0, 1'b0);
    run_check("x1", 1, 1, 1, 1, 1, 1'b0);

    // Upper data bits dropped, RESULT read-only, address 7 reads zero, oData holds.
    wr(3'd0, 32'hFFFF_FFF5);
    rd(3'd0, v);
    chk("mask_c0", v, 32'h5);
    wr(3'd6, 32'hFFFF_FFFF);
    rd(3'd6, v);
    chk("ro_result", v, 32'h4);
    wr(3'd7, 32'hFFFF_FFFF);
    rd(3'd7, v);
    chk("addr7", v, 32'h0);
    repeat (3) @(negedge iClk);
    chk("odata_hold", oData, 32'h0);

    // Register writes and a second start during a run must not disturb it.
    load(1, 2, 3, 4, 2);
    wr(3'd5, 32'h1);
    t0 = cyc;
    while (cyc < t0 + 4) @(negedge iClk);
    wr(3'd0, 32'd15);
    wr(3'd5, 32'h1);
    wait_done("busy_wr", t0);
    rd(3'd6, v);
    chk("busy_wr_result", v, 32'd49);
    rd(3'd0, v);
    chk("busy_wr_c0", v, 32'd15);
    repeat (20) @(negedge iClk);
    rd(3'd5, v);
    chk("busy_wr_status", v, 32'h2);

    // done_clear landing on the completion edge loses.
    load(3, 1, 4, 1, 5);
    wr(3'd5, 32'h3);
    t0 = cyc;
    while (cyc < t0 + 14) @(negedge iClk);
    wr(3'd5, 32'h6);
    chk("coincide_irq", 32'(oIrq), 32'h1);
    rd(3'd6, v);
    chk("coincide_result", v, 32'(poly(3, 1, 4, 1, 5)));
    wr(3'd5, 32'h4);

    // Reset mid-computation aborts without completion.
    load(1, 2, 3, 4, 2);
    wr(3'd5, 32'h3);
    t0 = cyc;
    while (cyc < t0 + 7) @(negedge iClk);
    iReset_n = 1'b0;
    #2;
    chk("midrst_odata", oData, 32'h0);
    @(negedge iClk);
    iReset_n = 1'b1;
    rd(3'd5, v);
    chk("midrst_status", v, 32'h0);
    rd(3'd6, v);
    chk("midrst_result", v, 32'h0);
    irq_seen = 0;
    repeat (20) begin
      @(negedge iClk);
      if (oIrq) irq_seen = 1;
    end
    chk("midrst_no_irq", 32'(irq_seen), 32'h0);
    run_check("post_rst", 2, 7, 0, 3, 6, 1'b1);
    wr(3'd5, 32'h4);

    for (int r = 0; r < 10; r++) begin
      for (int j = 0; j < 5; j++) c[j] = int'($urandom_range(0, 15));
      run_check($sformatf("rand%0d", r), c[0], c[1], c[2], c[3], c[4], 1'($urandom_range(0, 1)));
      wr(3'd5, 32'h4);
      chk($sformatf("rand%0d_clr", r), 32'(oIrq), 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
